// File: rtl/versat_arb_pkg.sv
// Shared types and constants for the Versat databus arbiter.
// Holds the FSM encoding, the grant-index width helper and the default watchdog width.
package versat_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned TIMEOUT_W_DEFAULT = 10;

    // Width of a master index; never narrower than one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/versat_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Built as a double-width masked priority encoder.
module versat_rr_pick
    import versat_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned GRANT_W = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               found,
    output logic [GRANT_W-1:0] winner
);

    logic [N_REQ-1:0]   masked;
    logic [2*N_REQ-1:0] dbl;

    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            masked[i] = req[i] && (GRANT_W'(i) >= ptr);
        end
    end

    // Low half: requests at/above ptr; high half: the wrapped-around remainder.
    assign dbl = {req, masked};

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < int'(2 * N_REQ); i++) begin
            if (!found && dbl[i]) begin
                found  = 1'b1;
                winner = GRANT_W'(i % int'(N_REQ));
            end
        end
    end

endmodule

// File: rtl/versat_databus_arbiter.sv
// Burst-locked round-robin arbiter sharing one external databus among N_MASTERS I/O units.
// Optional watchdog forced release is built when VERSAT_ARB_WATCHDOG_EN is defined.
module versat_databus_arbiter
    import versat_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    input  logic [N_MASTERS*8-1:0]          m_len,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            m_last,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    output logic [7:0]                      s_len,
    input  logic                            s_ready,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_last,
    output logic                            busy,
    output logic [$clog2(N_MASTERS)-1:0]    grant_id,
    output logic                            timeout_err
);

    localparam int unsigned GRANT_W = grant_w(N_MASTERS);
    localparam int unsigned STRB_W  = DATA_W / 8;

    if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_n_masters
        $error("N_MASTERS must be in 2..16");
    end
    if (TIMEOUT_W < 2) begin : g_bad_timeout_w
        $error("TIMEOUT_W must be at least 2");
    end

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0] grant_next;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_found;
    logic               locked;
    logic               beat;
    logic               wd_fire;

    logic [ADDR_W-1:0] addr_arr  [N_MASTERS];
    logic [DATA_W-1:0] wdata_arr [N_MASTERS];
    logic [STRB_W-1:0] strb_arr  [N_MASTERS];
    logic [7:0]        len_arr   [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
        assign strb_arr[i]  = m_wstrb[i*STRB_W +: STRB_W];
        assign len_arr[i]   = m_len[i*8 +: 8];
    end

    versat_rr_pick #(
        .N_REQ   (N_MASTERS),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req    (m_valid),
        .ptr    (rr_ptr_q),
        .found  (pick_found),
        .winner (pick_idx)
    );

    assign locked     = (state_q == LOCKED);
    assign beat       = s_valid & s_ready;
    assign grant_next = (grant_q == GRANT_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    // Databus side: address/data/len stay muxed from grant_id even while idle.
    always_comb begin
        s_valid = locked & m_valid[grant_q];
        s_addr  = addr_arr[grant_q];
        s_wdata = wdata_arr[grant_q];
        s_len   = len_arr[grant_q];
        s_wstrb = locked ? strb_arr[grant_q] : '0;
    end

    // Handshake back to the grantee only; suppressed during a forced release.
    always_comb begin
        m_ready = '0;
        m_last  = '0;
        if (locked && !wd_fire) begin
            m_ready[grant_q] = s_ready;
            m_last[grant_q]  = s_last;
        end
    end

    assign m_rdata = s_rdata;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    grant_d = pick_idx;
                end
            end
            LOCKED: begin
                if (wd_fire || (beat && s_last)) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef VERSAT_ARB_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_q, wd_d;

    assign wd_fire = locked && (wd_q == '1);

    // Counts beat-less locked cycles; idle (and thus every new lock) starts from zero.
    always_comb begin
        wd_d = '0;
        if (locked && !beat && !wd_fire) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout_err = wd_fire;
`else
    assign wd_fire     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy     = locked;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_versat_databus_arbiter.sv
// Scoreboard bench for versat_databus_arbiter: expected grants are queued by the stimulus
// and checked by an independent monitor; directed checks cover latency, stall, reset, read data.
module tb_versat_databus_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
`ifdef VERSAT_ARB_WATCHDOG_EN
    localparam int TW = 4;
`else
    localparam int TW = 10;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        m_valid;
    logic [N*AW-1:0]     m_addr  = '0;
    logic [N*DW-1:0]     m_wdata = '0;
    logic [N*DW/8-1:0]   m_wstrb = '0;
    logic [N*8-1:0]      m_len   = '0;
    logic [N-1:0]        m_ready;
    logic [DW-1:0]       m_rdata;
    logic [N-1:0]        m_last;
    logic                s_valid;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_wdata;
    logic [DW/8-1:0]     s_wstrb;
    logic [7:0]          s_len;
    logic                s_ready = 1'b0;
    logic [DW-1:0]       s_rdata = '0;
    logic                s_last;
    logic                busy;
    logic [1:0]          grant_id;
    logic                timeout_err;

    always #5 clk = ~clk;

    versat_databus_arbiter #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_len       (m_len),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .m_last      (m_last),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_len       (s_len),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .s_last      (s_last),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // Master models: each holds a count of outstanding bursts.
    int           bl [N];
    int           add_cnt [N];
    logic [N-1:0] stall = '0;
    logic [N-1:0] drop  = '0;

    always_comb begin
        for (int i = 0; i < N; i++) m_valid[i] = (bl[i] != 0) && !stall[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (drop[i]) bl[i] <= 0;
            else bl[i] <= bl[i] + add_cnt[i] - ((m_valid[i] && m_ready[i] && m_last[i]) ? 1 : 0);
        end
    end

    // Slave model: raises s_last on beat s_len of the burst.
    logic [7:0] bcnt;
    assign s_last = s_valid && (bcnt == s_len - 8'd1);

    always @(posedge clk or negedge rst) begin
        if (!rst) bcnt <= 8'd0;
        else if (s_valid && s_ready) bcnt <= s_last ? 8'd0 : bcnt + 8'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct {
        int            id;
        int            len;
        logic [AW-1:0] addr;
        bit            gap;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [AW-1:0] addr_of(input int i, input int len);
        return 32'h4000_0000 | (AW'(i) << 8) | AW'(len);
    endfunction

    task automatic add_burst(input int i, input int n, input int len, input bit rd);
        m_addr[i*AW +: AW]     = addr_of(i, len);
        m_wdata[i*DW +: DW]    = 32'hA5A5_0000 | DW'(i);
        m_wstrb[i*DW/8 +: DW/8] = rd ? 4'h0 : 4'hF;
        m_len[i*8 +: 8]        = 8'(len);
        add_cnt[i]             = n;
    endtask

    task automatic expect_grant(input int i, input int len, input bit gap);
        exp_t e;
        e.id   = i;
        e.len  = len;
        e.addr = addr_of(i, len);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) add_cnt[i] = 0;
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!busy && k < 50);
        check(name, busy, 1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((exp_q.size() != 0 || busy) && k < 300);
        check(name, {busy, 32'(exp_q.size())}, 0);
    endtask

    // Monitor: pops an expected grant on every lock entry and checks bursts as they run.
    exp_t cur;
    int   idle_cnt  = 0;
    int   beats     = 0;
    int   cur_len   = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", {30'd0, grant_id}, 32'hFFFF_FFFF);
            end else begin
                cur = exp_q.pop_front();
                check("grant_id", grant_id, cur.id);
                check("grant_addr", s_addr, cur.addr);
                if (cur.gap) check("grant_gap", idle_cnt, 1);
                cur_len = cur.len;
                beats   = 0;
            end
        end
        if (busy) begin
            check("nongrantee_quiet", (m_ready | m_last) & ~(4'b0001 << grant_id), 0);
            if (s_valid && s_ready) begin
                beats++;
                if (m_last[grant_id]) check("burst_beats", beats, cur_len);
            end
            idle_cnt = 0;
        end else begin
            check("idle_quiet", {s_valid, m_ready, m_last, s_wstrb, timeout_err}, 0);
            idle_cnt++;
        end
        prev_busy = busy;
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int at;
        for (int i = 0; i < N; i++) add_cnt[i] = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_outputs", {s_valid, s_wstrb, m_ready, m_last, timeout_err}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        s_ready = 1'b1;

        // Single requester: master 2, 4 beats, granted one cycle after the request.
        add_burst(2, 1, 4, 1'b0);
        expect_grant(2, 4, 1'b0);
        commit();
        @(negedge clk);
        check("b_arb_latency", busy, 0);
        @(negedge clk);
        check("b_busy", busy, 1);
        check("b_grant_id", grant_id, 2);
        check("b_wdata", s_wdata, 32'hA5A5_0002);
        wait_idle("b_drain");
        check("b_grant_hold", grant_id, 2);

        // rr_ptr now 3: masters 0 and 3 with single-beat bursts go 3 then 0.
        add_burst(0, 1, 1, 1'b0);
        add_burst(3, 1, 1, 1'b0);
        expect_grant(3, 1, 1'b0);
        expect_grant(0, 1, 1'b1);
        commit();
        wait_idle("c_drain");

        // Stall: grantee 1 drops valid for 3 cycles while master 3 waits.
        add_burst(1, 1, 4, 1'b0);
        add_burst(3, 1, 2, 1'b0);
        expect_grant(1, 4, 1'b0);
        expect_grant(3, 2, 1'b1);
        commit();
        wait_busy("s_wait_grant");
        @(posedge clk);
        #1 stall[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s_stall_valid", s_valid, 0);
            check("s_stall_lock", {busy, grant_id}, {1'b1, 2'd1});
        end
        @(posedge clk);
        #1 stall[1] = 1'b0;
        wait_idle("s_drain");

        // Reset during beat 2 of master 0's burst; pending master 3 wins afterwards.
        add_burst(0, 1, 4, 1'b0);
        add_burst(3, 1, 2, 1'b0);
        expect_grant(0, 4, 1'b0);
        expect_grant(3, 2, 1'b0);
        commit();
        wait_busy("e_wait_grant");
        check("e_grant0", grant_id, 0);
        @(negedge clk);
        #2;
        rst     = 1'b0;
        drop[0] = 1'b1;
        #1;
        check("e_rst_svalid", s_valid, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_mready", m_ready, 0);
        @(posedge clk);
        #1 drop[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        wait_idle("e_drain");

        // All four request continuously: 0,1,2,3,0 with one idle cycle between grants.
        add_burst(0, 2, 2, 1'b0);
        add_burst(1, 1, 2, 1'b0);
        add_burst(2, 1, 2, 1'b0);
        add_burst(3, 1, 2, 1'b0);
        expect_grant(0, 2, 1'b0);
        expect_grant(1, 2, 1'b1);
        expect_grant(2, 2, 1'b1);
        expect_grant(3, 2, 1'b1);
        expect_grant(0, 2, 1'b1);
        commit();
        wait_idle("d_drain");

        // Read: s_rdata passes straight through while master 0 reads.
        s_rdata = 32'hDEAD_BEEF;
        add_burst(0, 1, 1, 1'b1);
        expect_grant(0, 1, 1'b0);
        commit();
        wait_busy("f_wait_grant");
        check("f_rdata", m_rdata, 32'hDEAD_BEEF);
        check("f_mready", m_ready, 4'b0001);
        check("f_wstrb", s_wstrb, 0);
        wait_idle("f_drain");
        s_rdata = '0;

`ifdef VERSAT_ARB_WATCHDOG_EN
        // Watchdog: grantee 0 never sees ready; forced release then master 2 is next.
        s_ready = 1'b0;
        add_burst(0, 1, 3, 1'b0);
        expect_grant(0, 3, 1'b0);
        commit();
        wait_busy("w_wait_grant");
        add_burst(2, 1, 1, 1'b0);
        expect_grant(2, 1, 1'b0);
        commit();
        cyc = 0;
        at  = -1;
        while (at < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (timeout_err) at = cyc;
        end
        check("w_delay", at, 15);
        check("w_offender_ready", m_ready, 0);
        @(posedge clk);
        #1;
        s_ready = 1'b1;
        drop[0] = 1'b1;
        @(negedge clk);
        check("w_pulse_once", timeout_err, 0);
        check("w_release", busy, 0);
        @(posedge clk);
        #1 drop[0] = 1'b0;
        wait_idle("w_drain");
`else
        cyc = 0;
        at  = 0;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
